// File: rtl/alu_pkg.sv
// Shared ALU-control constants: ALUop encodings, main-decoder op classes and
// the funct3 values that select each ALU operation.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] OPC_MEM = 2'b00;
  localparam logic [1:0] OPC_BR  = 2'b01;
  localparam logic [1:0] OPC_R   = 2'b10;
  localparam logic [1:0] OPC_I   = 2'b11;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU-control decode: op class + funct3/funct7[5] -> {alu_op, illegal}.
// Unsupported combinations fall back to ADD with illegal raised.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] op_class_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_op_o,
  output logic       illegal_o
);

  // Map op class and function fields onto the ALU encoding
  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (op_class_i)
      OPC_MEM: alu_op_o = ALU_ADD;
      OPC_BR:  alu_op_o = ALU_SUB;
      OPC_R, OPC_I: begin
        case (funct3_i)
          F3_ADD: begin
            // Only R-type uses bit 30 to select subtract; I-type has no SUBI
            if (op_class_i == OPC_R && funct7b5_i) begin
              alu_op_o = ALU_SUB;
            end else begin
              alu_op_o = ALU_ADD;
            end
          end
          F3_AND: alu_op_o = ALU_AND;
          F3_OR:  alu_op_o = ALU_OR;
          F3_SLT: alu_op_o = ALU_SLT;
          default: begin
            alu_op_o  = ALU_ADD;
            illegal_o = 1'b1;
          end
        endcase
      end
      default: begin
        alu_op_o  = ALU_ADD;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control stage: decodes the request, carries operands, and
// buffers them in a 2-entry main/skid buffer with a flop-driven in_ready.
module alu_ctrl_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op_class,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_op,
  output logic [XLEN-1:0]  out_a,
  output logic [XLEN-1:0]  out_b,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  logic [3:0]       dec_op_s;
  logic             dec_illegal_s;
  logic             accept_s;

  logic             main_valid_q, main_valid_d;
  logic [3:0]       main_op_q, main_op_d;
  logic [XLEN-1:0]  main_a_q, main_a_d;
  logic [XLEN-1:0]  main_b_q, main_b_d;
  logic             main_ill_q, main_ill_d;

  logic             skid_valid_q, skid_valid_d;
  logic [3:0]       skid_op_q, skid_op_d;
  logic [XLEN-1:0]  skid_a_q, skid_a_d;
  logic [XLEN-1:0]  skid_b_q, skid_b_d;
  logic             skid_ill_q, skid_ill_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  alu_op_decode u_decode (
    .op_class_i (in_op_class),
    .funct3_i   (in_funct3),
    .funct7b5_i (in_funct7b5),
    .alu_op_o   (dec_op_s),
    .illegal_o  (dec_illegal_s)
  );

  assign accept_s = in_valid && !skid_valid_q;

  // Next-state for the main/skid pair and the illegal counter
  always_comb begin
    main_valid_d = main_valid_q;
    main_op_d    = main_op_q;
    main_a_d     = main_a_q;
    main_b_d     = main_b_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_op_d    = skid_op_q;
    skid_a_d     = skid_a_q;
    skid_b_d     = skid_b_q;
    skid_ill_d   = skid_ill_q;
    cnt_d        = cnt_q;

    if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        // Older skid entry goes out first to keep FIFO order
        main_valid_d = 1'b1;
        main_op_d    = skid_op_q;
        main_a_d     = skid_a_q;
        main_b_d     = skid_b_q;
        main_ill_d   = skid_ill_q;
        if (accept_s) begin
          skid_valid_d = 1'b1;
          skid_op_d    = dec_op_s;
          skid_a_d     = in_a;
          skid_b_d     = in_b;
          skid_ill_d   = dec_illegal_s;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (accept_s) begin
        main_valid_d = 1'b1;
        main_op_d    = dec_op_s;
        main_a_d     = in_a;
        main_b_d     = in_b;
        main_ill_d   = dec_illegal_s;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_d = 1'b1;
      skid_op_d    = dec_op_s;
      skid_a_d     = in_a;
      skid_b_d     = in_b;
      skid_ill_d   = dec_illegal_s;
    end else begin
      skid_valid_d = skid_valid_q;
    end

    if (accept_s && dec_illegal_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards any in-flight entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_op_q    <= 4'b0000;
      main_a_q     <= {XLEN{1'b0}};
      main_b_q     <= {XLEN{1'b0}};
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_op_q    <= 4'b0000;
      skid_a_q     <= {XLEN{1'b0}};
      skid_b_q     <= {XLEN{1'b0}};
      skid_ill_q   <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      main_valid_q <= main_valid_d;
      main_op_q    <= main_op_d;
      main_a_q     <= main_a_d;
      main_b_q     <= main_b_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_op_q    <= skid_op_d;
      skid_a_q     <= skid_a_d;
      skid_b_q     <= skid_b_d;
      skid_ill_q   <= skid_ill_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready      = !skid_valid_q;
  assign out_valid     = main_valid_q;
  assign out_alu_op    = main_op_q;
  assign out_a         = main_a_q;
  assign out_b         = main_b_q;
  assign out_illegal   = main_ill_q;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: expected entries are queued on accept
// and compared as the DUT hands them to the ALU side.
module tb_alu_ctrl_stage;

  localparam int XLEN  = 64;
  localparam int CNT_W = 2;

  typedef struct {
    logic [3:0]      op;
    logic            ill;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op_class;
  logic [2:0]       in_funct3;
  logic             in_funct7b5;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_alu_op;
  logic [XLEN-1:0]  out_a;
  logic [XLEN-1:0]  out_b;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_count;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  alu_ctrl_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op_class   (in_op_class),
    .in_funct3     (in_funct3),
    .in_funct7b5   (in_funct7b5),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_alu_op    (out_alu_op),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_illegal   (out_illegal),
    .illegal_count (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written as a flat table, independent of the RTL structure
  function automatic logic [4:0] ref_dec(input logic [1:0] c, input logic [2:0] f3, input logic f7);
    if (c == 2'b00) return {4'b0010, 1'b0};
    if (c == 2'b01) return {4'b0110, 1'b0};
    case (f3)
      3'b000:  return (c == 2'b10 && f7) ? {4'b0110, 1'b0} : {4'b0010, 1'b0};
      3'b111:  return {4'b0000, 1'b0};
      3'b110:  return {4'b0001, 1'b0};
      3'b010:  return {4'b0111, 1'b0};
      default: return {4'b0010, 1'b1};
    endcase
  endfunction

  // Monitor: a transfer happens at the next rising edge when both handshakes are high
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got op=%b a=%0d, required no output", out_alu_op, out_a);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_alu_op !== e.op || out_illegal !== e.ill || out_a !== e.a || out_b !== e.b) begin
          errors++;
          $display("FAIL sb_data: got op=%b ill=%b a=%0d b=%0d, required op=%b ill=%b a=%0d b=%0d",
                   out_alu_op, out_illegal, out_a, out_b, e.op, e.ill, e.a, e.b);
        end
      end
    end
  end

  // Drives one request; returns the number of cycles it waited for in_ready
  task automatic send(input logic [1:0] c, input logic [2:0] f3, input logic f7,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, output int waited);
    bit   done;
    exp_t e;
    logic [4:0] d;
    done        = 1'b0;
    waited      = 0;
    in_valid    = 1'b1;
    in_op_class = c;
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_a        = a;
    in_b        = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        d     = ref_dec(c, f3, f7);
        e.op  = d[4:1];
        e.ill = d[0];
        e.a   = a;
        e.b   = b;
        sb.push_back(e);
        done  = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_op_class = 2'b00; in_funct3 = 3'b000; in_funct7b5 = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_alu_op !== 4'b0000 || out_a !== 64'd0 ||
        out_b !== 64'd0 || out_illegal !== 1'b0 || illegal_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b rdy=%b op=%b a=%0d b=%0d ill=%b cnt=%0d, required 0 1 0000 0 0 0 0",
               out_valid, in_ready, out_alu_op, out_a, out_b, out_illegal, illegal_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    logic [1:0] cls [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01};
    logic [2:0] f3s [7] = '{3'b000, 3'b111, 3'b110, 3'b010, 3'b000, 3'b101, 3'b011};
    logic       f7s [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] req [7] = '{4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0010, 4'b0010, 4'b0110};
    int w;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(cls[i], f3s[i], f7s[i], 64'(i * 3 + 5), 64'(i + 1), w);
      idle();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_alu_op !== req[i]) begin
        errors++;
        $display("FAIL decode_%0d: got v=%b op=%b, required v=1 op=%b", i, out_valid, out_alu_op, req[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_datapath();
    int w;
    out_ready = 1'b1;
    send(2'b01, 3'b000, 1'b0, 64'd1000, 64'd1, w);
    idle();
    @(negedge clk);
    checks++;
    if (out_a !== 64'd1000 || out_b !== 64'd1 || out_alu_op !== 4'b0110 || (out_a - out_b) !== 64'd999) begin
      errors++;
      $display("FAIL datapath: got a=%0d b=%0d op=%b, required a=1000 b=1 op=0110 diff=999",
               out_a, out_b, out_alu_op);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b0;
    send(2'b10, 3'b111, 1'b0, 64'd11, 64'd12, w);
    send(2'b10, 3'b110, 1'b0, 64'd21, 64'd22, w);
    idle();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_a !== 64'd11 || out_alu_op !== 4'b0000) begin
      errors++;
      $display("FAIL bp_hold: got rdy=%b v=%b a=%0d op=%b, required rdy=0 v=1 a=11 op=0000",
               in_ready, out_valid, out_a, out_alu_op);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_a !== 64'd11 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got a=%0d rdy=%b, required a=11 rdy=0", out_a, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_a !== 64'd21 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: got v=%b a=%0d rdy=%b, required v=1 a=21 rdy=1", out_valid, out_a, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got v=%b, required 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int w;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(2'(i % 4), 3'b111, 1'b0, 64'(100 + i), 64'(200 + i), w);
      checks++;
      if (w !== 0) begin
        errors++;
        $display("FAIL stream_ready_%0d: got wait=%0d, required 0", i, w);
      end
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_valid_%0d: got v=%b, required 1", i, out_valid);
        end
      end
    end
    idle();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_a !== 64'd107) begin
      errors++;
      $display("FAIL stream_last: got v=%b a=%0d, required v=1 a=107", out_valid, out_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int w;
    out_ready = 1'b1;
    send(2'b10, 3'b001, 1'b0, 64'd7, 64'd8, w);
    idle();
    @(negedge clk);
    checks++;
    if (out_illegal !== 1'b1 || out_alu_op !== 4'b0010 || illegal_count !== 2'd1) begin
      errors++;
      $display("FAIL illegal_one: got ill=%b op=%b cnt=%0d, required ill=1 op=0010 cnt=1",
               out_illegal, out_alu_op, illegal_count);
    end
    @(posedge clk); #1;
    send(2'b11, 3'b100, 1'b0, 64'd9, 64'd1, w);
    idle();
    @(negedge clk);
    checks++;
    if (illegal_count !== 2'd2) begin
      errors++;
      $display("FAIL illegal_two: got cnt=%0d, required 2", illegal_count);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(2'b10, 3'b101, 1'b1, 64'(i), 64'(i), w);
    send(2'b10, 3'b000, 1'b0, 64'd1, 64'd1, w);
    idle();
    @(negedge clk);
    checks++;
    if (illegal_count !== 2'd3 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_sat: got cnt=%0d ill=%b, required cnt=3 ill=0", illegal_count, out_illegal);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int w;
    out_ready = 1'b0;
    send(2'b01, 3'b000, 1'b0, 64'd55, 64'd66, w);
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_alu_op !== 4'b0000 || out_a !== 64'd0 ||
        illegal_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b rdy=%b op=%b a=%0d cnt=%0d, required 0 1 0000 0 0",
               out_valid, in_ready, out_alu_op, out_a, illegal_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: got v=%b, required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_datapath();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    end
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
